// File: rtl/queue_sched_pkg.sv
// Shared types and width helpers for the queue pop scheduler.
package queue_sched_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } state_t;

  // Queue index width; a 2-queue scheduler still needs one bit.
  function automatic int unsigned id_width(int unsigned m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  // Burst counter width, able to hold the value max_burst itself.
  function automatic int unsigned cnt_width(int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first eligible requester after base_i, modulo M.
module rr_pick #(
  parameter int unsigned M    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [M-1:0]    req_i,
  input  logic [ID_W-1:0] base_i,
  input  logic [M-1:0]    excl_i,
  output logic [M-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  logic [M-1:0] cand;

  assign cand = req_i & ~excl_i;

  // Scan base+1 .. base+M; explicit modulo keeps non-power-of-2 M correct.
  always_comb begin
    int unsigned c;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int unsigned i = 1; i <= M; i++) begin
      c = (32'(base_i) + i) % M;
      if (!any_o && cand[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = ID_W'(c);
      end
    end
  end

endmodule

// File: rtl/queue_pop_sched.sv
// Round-robin, burst-limited pop scheduler draining M queues onto one registered egress.
module queue_pop_sched
  import queue_sched_pkg::*;
#(
  parameter int unsigned M         = 4,
  parameter int unsigned W         = 32,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned ID_W     = id_width(M)
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic [M-1:0]    i_q_empty_w,
  input  logic [M*W-1:0]  i_q_pop_dat,
  output logic [M-1:0]    o_q_pop,
  output logic            o_egr_vld,
  output logic [W-1:0]    o_egr_dat,
  output logic [ID_W-1:0] o_egr_id,
  input  logic            i_egr_rdy
);

  localparam int unsigned CNT_W = cnt_width(MAX_BURST);

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            vld_q, vld_d;
  logic [W-1:0]    dat_q, dat_d;
  logic [ID_W-1:0] id_q, id_d;

  logic            can_load;
  logic [M-1:0]    req;
  logic [M-1:0]    owner_oh;
  logic [M-1:0]    excl;
  logic            keep;
  logic [M-1:0]    pick_gnt;
  logic [ID_W-1:0] pick_idx;
  logic            pick_any;
  logic [M-1:0]    gnt;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_any;
  logic [W-1:0]    gnt_dat;

  assign can_load = ~vld_q | i_egr_rdy;
  assign req      = ~i_q_empty_w;

  // One-hot of the current owner / last-grant pointer.
  always_comb begin
    owner_oh        = '0;
    owner_oh[ptr_q] = 1'b1;
  end

  // Owner keeps the grant while it has data and budget left.
  assign keep = (state_q == StBurst) && req[ptr_q] && (cnt_q < CNT_W'(MAX_BURST));

  // Re-arbitration skips the owner only when someone else is waiting.
  assign excl = ((state_q == StBurst) && ((req & ~owner_oh) != '0)) ? owner_oh : '0;

  rr_pick #(
    .M    (M),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req_i  (req),
    .base_i (ptr_q),
    .excl_i (excl),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Output: grant selection and pop strobe.
  always_comb begin
    if (keep) begin
      gnt     = owner_oh;
      gnt_idx = ptr_q;
      gnt_any = 1'b1;
    end else begin
      gnt     = pick_gnt;
      gnt_idx = pick_idx;
      gnt_any = pick_any;
    end
    gnt_dat = '0;
    for (int unsigned q = 0; q < M; q++) begin
      if (gnt[q]) gnt_dat = i_q_pop_dat[q*W +: W];
    end
    o_q_pop = can_load ? gnt : '0;
  end

  // Next state: load on pop, drain when idle, hold everything under backpressure.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    id_d    = id_q;
    if (can_load) begin
      if (gnt_any) begin
        ptr_d = gnt_idx;
        vld_d = 1'b1;
        dat_d = gnt_dat;
        id_d  = gnt_idx;
        if (MAX_BURST == 1) begin
          state_d = StIdle;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = StBurst;
          cnt_d   = keep ? cnt_q + CNT_W'(1) : CNT_W'(1);
        end
      end else begin
        state_d = StIdle;
        vld_d   = 1'b0;
        cnt_d   = '0;
      end
    end
  end

  // State register; pointer resets to M-1 so queue 0 wins first.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StIdle;
      ptr_q   <= ID_W'(M - 1);
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      id_q    <= id_d;
    end
  end

  assign o_egr_vld = vld_q;
  assign o_egr_dat = dat_q;
  assign o_egr_id  = id_q;

`ifndef SYNTHESIS
  a_pop_onehot : assert property (@(posedge clk) disable iff (!arst_n) $onehot0(o_q_pop));
  a_pop_nonempty : assert property (@(posedge clk) disable iff (!arst_n)
    (o_q_pop & i_q_empty_w) == '0);
  a_egr_stable : assert property (@(posedge clk) disable iff (!arst_n)
    (o_egr_vld && !i_egr_rdy) |=> ($stable(o_egr_dat) && $stable(o_egr_id)));
`endif

endmodule

// File: tb/tb_queue_pop_sched.sv
// Directed bench: two schedulers (MAX_BURST=1 and 4) fed by behavioural queue models.
module tb_queue_pop_sched;

  localparam int unsigned M = 4;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic arst_n;

  always #5 clk = ~clk;

  logic [1:0][M-1:0]   empty;
  logic [1:0][M*W-1:0] pdat;
  logic [1:0][M-1:0]   pop;
  logic [1:0]          rdy;
  logic [1:0]          vld;
  logic [1:0][W-1:0]   odat;
  logic [1:0][1:0]     oid;

  logic [W-1:0] mem [2][M][16];
  logic [7:0]   wr  [2][M];
  logic [7:0]   rd  [2][M];
  int           xfer [2];

  int checks;
  int failures;

  queue_pop_sched #(.M(M), .W(W), .MAX_BURST(1)) dut0 (
    .clk         (clk),
    .arst_n      (arst_n),
    .i_q_empty_w (empty[0]),
    .i_q_pop_dat (pdat[0]),
    .o_q_pop     (pop[0]),
    .o_egr_vld   (vld[0]),
    .o_egr_dat   (odat[0]),
    .o_egr_id    (oid[0]),
    .i_egr_rdy   (rdy[0])
  );

  queue_pop_sched #(.M(M), .W(W), .MAX_BURST(4)) dut1 (
    .clk         (clk),
    .arst_n      (arst_n),
    .i_q_empty_w (empty[1]),
    .i_q_pop_dat (pdat[1]),
    .o_q_pop     (pop[1]),
    .o_egr_vld   (vld[1]),
    .o_egr_dat   (odat[1]),
    .o_egr_id    (oid[1]),
    .i_egr_rdy   (rdy[1])
  );

  // Queue models: read side advances on pop, transfers are counted.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int d = 0; d < 2; d++) begin
        xfer[d] <= 0;
        for (int q = 0; q < M; q++) rd[d][q] <= 8'd0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (vld[d] && rdy[d]) xfer[d] <= xfer[d] + 1;
        for (int q = 0; q < M; q++) if (pop[d][q]) rd[d][q] <= rd[d][q] + 8'd1;
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      for (int q = 0; q < M; q++) begin
        empty[d][q]          = (rd[d][q] == wr[d][q]);
        pdat[d][q*W +: W]    = mem[d][q][rd[d][q][3:0]];
      end
    end
  end

  function automatic logic [W-1:0] mk(int d, int q, int n);
    return 32'(32'hA000_0000 | (d << 16) | (q << 8) | n);
  endfunction

  task automatic push(int d, int q, int n);
    mem[d][q][wr[d][q][3:0]] = mk(d, q, n);
    wr[d][q] = wr[d][q] + 8'd1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    rdy    = 2'b11;
    for (int d = 0; d < 2; d++) for (int q = 0; q < M; q++) wr[d][q] = 8'd0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({vld[d], oid[d], odat[d]} !== 35'd0) begin
        failures++;
        $display("FAIL reset_regs[%0d]: got %h expected 0", d, {vld[d], oid[d], odat[d]});
      end
    end
    arst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({vld[d], pop[d]} !== 5'd0) begin
          failures++;
          $display("FAIL idle[%0d] cycle %0d: vld/pop got %b expected 0", d, c, {vld[d], pop[d]});
        end
      end
    end
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    for (int n = 0; n < 2; n++) for (int q = 0; q < 4; q++) push(0, q, n);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({vld[0], oid[0], odat[0]} !== {1'b1, 2'(i % 4), mk(0, i % 4, i / 4)}) begin
        failures++;
        $display("FAIL rr[%0d]: got vld=%b id=%0d dat=%h expected id=%0d dat=%h", i, vld[0],
                 oid[0], odat[0], i % 4, mk(0, i % 4, i / 4));
      end
    end
    @(negedge clk);
    checks++;
    if (vld[0] !== 1'b0) begin
      failures++;
      $display("FAIL rr_drain: vld got %b expected 0", vld[0]);
    end
  endtask

  task automatic test_burst();
    int exp_id [13] = '{0, 0, 0, 0, 2, 2, 2, 0, 0, 0, 0, 0, 0};
    int seen [M] = '{0, 0, 0, 0};
    @(negedge clk);
    for (int n = 0; n < 10; n++) push(1, 0, n);
    for (int n = 0; n < 3; n++) push(1, 2, n);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      checks++;
      if ({vld[1], oid[1], odat[1]} !== {1'b1, 2'(exp_id[i]), mk(1, exp_id[i], seen[exp_id[i]])})
      begin
        failures++;
        $display("FAIL burst[%0d]: got vld=%b id=%0d dat=%h expected id=%0d dat=%h", i, vld[1],
                 oid[1], odat[1], exp_id[i], mk(1, exp_id[i], seen[exp_id[i]]));
      end
      seen[exp_id[i]]++;
    end
    @(negedge clk);
    checks++;
    if (vld[1] !== 1'b0) begin
      failures++;
      $display("FAIL burst_drain: vld got %b expected 0", vld[1]);
    end
  endtask

  task automatic test_backpressure();
    int base;
    @(negedge clk);
    base = xfer[1];
    for (int n = 0; n < 4; n++) push(1, 1, n);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({vld[1], oid[1], odat[1]} !== {1'b1, 2'd1, mk(1, 1, 0)}) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got vld=%b id=%0d dat=%h expected dat=%h", c, vld[1],
                 oid[1], odat[1], mk(1, 1, 0));
      end
      if (c == 0) rdy[1] = 1'b0;
      #1;
      checks++;
      if (pop[1] !== 4'b0000) begin
        failures++;
        $display("FAIL bp_nopop[%0d]: pop got %b expected 0000", c, pop[1]);
      end
    end
    rdy[1] = 1'b1;
    #1;
    checks++;
    if (pop[1] !== 4'b0010) begin
      failures++;
      $display("FAIL bp_resume_pop: pop got %b expected 0010", pop[1]);
    end
    for (int n = 1; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if ({vld[1], oid[1], odat[1]} !== {1'b1, 2'd1, mk(1, 1, n)}) begin
        failures++;
        $display("FAIL bp_stream[%0d]: got vld=%b dat=%h expected %h", n, vld[1], odat[1],
                 mk(1, 1, n));
      end
    end
    @(negedge clk);
    checks++;
    if ({vld[1], 32'(xfer[1] - base)} !== {1'b0, 32'd4}) begin
      failures++;
      $display("FAIL bp_count: vld=%b transfers=%0d expected vld=0 transfers=4", vld[1],
               xfer[1] - base);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    push(1, 3, 0);
    @(negedge clk);
    checks++;
    if ({vld[1], oid[1], odat[1]} !== {1'b1, 2'd3, mk(1, 3, 0)}) begin
      failures++;
      $display("FAIL wrap_setup: got vld=%b id=%0d dat=%h expected id=3", vld[1], oid[1], odat[1]);
    end
    @(negedge clk);
    push(1, 3, 1);
    push(1, 1, 9);
    @(negedge clk);
    checks++;
    if ({vld[1], oid[1], odat[1]} !== {1'b1, 2'd1, mk(1, 1, 9)}) begin
      failures++;
      $display("FAIL wrap_first: got vld=%b id=%0d dat=%h expected id=1", vld[1], oid[1], odat[1]);
    end
    @(negedge clk);
    checks++;
    if ({vld[1], oid[1], odat[1]} !== {1'b1, 2'd3, mk(1, 3, 1)}) begin
      failures++;
      $display("FAIL wrap_second: got vld=%b id=%0d dat=%h expected id=3", vld[1], oid[1],
               odat[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int exp_q [3] = '{1, 2, 3};
    int exp_n [3] = '{0, 7, 0};
    @(negedge clk);
    for (int n = 0; n < 6; n++) push(1, 2, n);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if ({vld[1], oid[1], odat[1]} !== {1'b1, 2'd2, mk(1, 2, n)}) begin
        failures++;
        $display("FAIL mr_pre[%0d]: got vld=%b id=%0d dat=%h", n, vld[1], oid[1], odat[1]);
      end
    end
    #1 arst_n = 1'b0;
    #1;
    checks++;
    if ({vld[1], oid[1], odat[1]} !== 35'd0) begin
      failures++;
      $display("FAIL mr_async: got vld=%b id=%0d dat=%h expected all 0", vld[1], oid[1], odat[1]);
    end
    for (int d = 0; d < 2; d++) for (int q = 0; q < M; q++) wr[d][q] = 8'd0;
    push(1, 3, 0);
    push(1, 2, 7);
    push(1, 1, 0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({vld[1], oid[1], odat[1]} !== {1'b1, 2'(exp_q[i]), mk(1, exp_q[i], exp_n[i])}) begin
        failures++;
        $display("FAIL mr_post[%0d]: got vld=%b id=%0d dat=%h expected id=%0d", i, vld[1], oid[1],
                 odat[1], exp_q[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (vld[1] !== 1'b0) begin
      failures++;
      $display("FAIL mr_drain: vld got %b expected 0", vld[1]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_round_robin();
    test_burst();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/queue_pop_sched.md
Name: queue_pop_sched

Overview:
- Round-robin pop scheduler that drains M independent queue_rf instances onto one registered egress channel with valid/ready handshake.
- Observes each queue's empty status and combinational head data, and issues at most one pop per cycle.
- Supports bounded bursts per queue, to amortise switching, while keeping fairness.
- Sits between the per-source ingress queues and a shared downstream consumer (e.g. a single pipeline port).

Parameters:
- M, 4: number of queues scheduled; M >= 2.
- W, 32: payload width; must match the queue_rf W.
- MAX_BURST, 4: maximum consecutive pops granted to one queue while others are non-empty; >= 1.
- ID_W, $clog2(M): derived localparam; width of the queue index.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset; asynchronous, active-low.
- i_q_empty_w  in  M  per-queue empty status (queue_rf o_empty_w).
- i_q_pop_dat  in  M*W  per-queue head data; queue q occupies bits [q*W +: W].
- o_q_pop  out  M  per-queue pop strobe, one-hot or zero.
- o_egr_vld  out  1  egress entry valid (registered).
- o_egr_dat  out  W  egress payload (registered).
- o_egr_id  out  ID_W  index of the source queue (registered).
- i_egr_rdy  in  1  downstream accepts; transfer occurs when o_egr_vld & i_egr_rdy.

Behaviour:
- Reset values: o_egr_vld=0, o_egr_dat=0, o_egr_id=0, state=IDLE, last-grant pointer=M-1 (so queue 0 has first priority), burst_cnt=0. o_q_pop is combinational and is 0 whenever egress cannot accept.
- Egress slot: can_load = ~o_egr_vld | i_egr_rdy.
- Request vector: req = ~i_q_empty_w.
- Pop rule: o_q_pop[g] = can_load & req[g] for the single grant g; otherwise all zero.
- Load rule: on a pop, the egress register loads i_q_pop_dat[g] and g next cycle, and o_egr_vld=1.
- Drain rule: if can_load and no request, o_egr_vld<=0.
- Throughput and latency:
  - Head data is captured in the same cycle as the pop.
  - Latency is 1 cycle from queue head to egress.
  - Full throughput is 1 entry/cycle under continuous i_egr_rdy.
- Backpressure: while o_egr_vld & ~i_egr_rdy:
  - no pops;
  - egress registers hold;
  - state, pointer and burst_cnt hold.
- FSM states: IDLE (no owner) and BURST (owner = last-grant pointer).
- IDLE:
  - g = first requester scanning from pointer+1 modulo M.
  - On a pop: pointer<=g, burst_cnt<=1, go to BURST. If MAX_BURST==1, stay IDLE with pointer<=g.
- BURST:
  - Keep the owner when req[owner] and burst_cnt < MAX_BURST; this pops the owner and increments burst_cnt.
  - Otherwise, re-arbitrate round-robin from owner+1, excluding the owner unless it is the only requester. On a pop: pointer<=g, burst_cnt<=1.
  - If no requests, go to IDLE and keep the pointer.
- Burst limit with other requesters empty: if the owner reaches MAX_BURST and is still the only requester, it is re-granted with burst_cnt<=1. No idle cycle is inserted.
- Queue going empty mid-burst: the queue's empty status updates the cycle after its last pop. Grant then moves in that cycle; no bubble is caused by the scheduler.
- Push into an empty queue: the queue_rf empty status deasserts the cycle after its push. The scheduler requires no bypass.
- burst_cnt: width $clog2(MAX_BURST+1) bits; saturates at MAX_BURST, never wraps.
- Pointer wrap: M-1 -> 0. For non-power-of-2 M, the modulo is explicit.
- Asynchronous reset mid-operation:
  - the egress entry is dropped (o_egr_vld=0 immediately);
  - queue contents are untouched by this block;
  - the queues are reset by the same arst_n.
- Assertions:
  - $onehot0(o_q_pop);
  - no pop to an empty queue;
  - o_egr_dat/o_egr_id stable while o_egr_vld & ~i_egr_rdy.

Decomposition:
- queue_sched_pkg holds:
  - state_t enum {IDLE, BURST};
  - a localparam function for clog2-safe ID_W (1 when M==2);
  - the burst counter width helper.
- Sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: req[M], base pointer, exclude mask.
  - Outputs: one-hot grant, index, any.
  - Instanced once.

Test Plan:
- Reset/idle: arst_n low, then all queues empty for 10 cycles -> o_egr_vld=0 and o_q_pop=0 throughout.
- Round-robin with MAX_BURST=1: queues 0–3 each hold 2 entries, i_egr_rdy=1 -> egress ids are 0,1,2,3,0,1,2,3 on consecutive cycles with no bubbles.
- Bursting with MAX_BURST=4: q0 holds 10 entries and q2 holds 3, rdy=1 -> ids 0,0,0,0,2,2,2,0,0,0,0,0,0. q0 repeats unbounded once alone.
- Backpressure: stream from q1 with i_egr_rdy toggled 1,0,0,1 -> egress data held stable over the 2 stall cycles, no o_q_pop during stalls, no loss or duplication (scoreboard).
- Wrap/skip: only q3 and q1 non-empty (1 entry each), pointer=3 -> grants q1 then q3.
- Mid-burst reset: assert arst_n at burst_cnt=2 -> o_egr_vld=0 asynchronously. After release, the first grant goes to the lowest-index non-empty queue.
